// File: rtl/adc_spi_master.sv
// rtl/adc_spi_master.sv - free-running 2-channel 12-bit ADC SPI master, 8-bit results (optional ADC_AVG_EN 4-sample averaging)
module adc_spi_master #(
    parameter int CLK_DIV  = 25,
    parameter int CONV_GAP = 50
) (
    input  logic       CLK,
    input  logic       RST,
    output logic       SPI_SCK,
    output logic       SPI_AD,
    output logic       SPI_DIN,
    input  logic       SPI_DOUT,
    output logic [7:0] adc_accel,
    output logic [7:0] adc_cds,
    output logic       accel_valid,
    output logic       cds_valid
);

    typedef enum logic [1:0] {GAP, SHIFT, LATCH} state_t;

    state_t      state;
    logic [9:0]  gap_cnt;
    logic [7:0]  half_cnt;
    logic [5:0]  edge_cnt;
    logic [5:0]  next_edge;
    logic        channel;
    logic [11:0] shreg;
    logic [7:0]  result;

    // next_edge counts half-periods: odd = SCK rise, even = SCK fall, 37 = trailing CS hold ends
    assign next_edge = edge_cnt + 6'd1;

`ifdef ADC_AVG_EN
    logic [11:0] hist [2][4];
    logic [13:0] avg_sum;

    always_comb begin
        avg_sum = 14'(shreg) + 14'(hist[channel][0]) + 14'(hist[channel][1]) + 14'(hist[channel][2]);
        result  = avg_sum[13:6];
    end
`else
    always_comb begin
        result = shreg[11:4];
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= GAP;
            gap_cnt     <= '0;
            half_cnt    <= '0;
            edge_cnt    <= '0;
            channel     <= 1'b0;
            shreg       <= '0;
            SPI_SCK     <= 1'b0;
            SPI_AD      <= 1'b1;
            SPI_DIN     <= 1'b0;
            adc_accel   <= '0;
            adc_cds     <= '0;
            accel_valid <= 1'b0;
            cds_valid   <= 1'b0;
`ifdef ADC_AVG_EN
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < 4; i++) begin
                    hist[c][i] <= '0;
                end
            end
`endif
        end else begin
            accel_valid <= 1'b0;
            cds_valid   <= 1'b0;
            case (state)
                GAP: begin
                    SPI_AD  <= 1'b1;
                    SPI_SCK <= 1'b0;
                    if (gap_cnt == 10'(CONV_GAP - 1)) begin
                        state    <= SHIFT;
                        gap_cnt  <= '0;
                        half_cnt <= '0;
                        edge_cnt <= '0;
                        SPI_AD   <= 1'b0;
                        SPI_DIN  <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 10'd1;
                    end
                end
                SHIFT: begin
                    if (half_cnt == 8'(CLK_DIV - 1)) begin
                        half_cnt <= '0;
                        edge_cnt <= next_edge;
                        if (next_edge == 6'd37) begin
                            state   <= LATCH;
                            SPI_AD  <= 1'b1;
                            SPI_DIN <= 1'b0;
                            if (channel) begin
                                adc_cds   <= result;
                                cds_valid <= 1'b1;
                            end else begin
                                adc_accel   <= result;
                                accel_valid <= 1'b1;
                            end
`ifdef ADC_AVG_EN
                            hist[channel][0] <= shreg;
                            hist[channel][1] <= hist[channel][0];
                            hist[channel][2] <= hist[channel][1];
                            hist[channel][3] <= hist[channel][2];
`endif
                        end else begin
                            SPI_SCK <= next_edge[0];
                            if (next_edge[0]) begin
                                // rises r6..r17 carry B11..B0; earlier rises are command/null
                                if (next_edge >= 6'd13) begin
                                    shreg <= {shreg[10:0], SPI_DOUT};
                                end
                            end else begin
                                case (next_edge)
                                    6'd2:    SPI_DIN <= 1'b1;
                                    6'd4:    SPI_DIN <= channel;
                                    6'd6:    SPI_DIN <= 1'b1;
                                    default: SPI_DIN <= 1'b0;
                                endcase
                            end
                        end
                    end else begin
                        half_cnt <= half_cnt + 8'd1;
                    end
                end
                LATCH: begin
                    channel <= ~channel;
                    gap_cnt <= '0;
                    state   <= GAP;
                end
                default: state <= GAP;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_master.sv
// tb/tb_adc_spi_master.sv - randomized self-checking bench for adc_spi_master with a behavioural ADC model
module tb_adc_spi_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck, ad, din;
    logic       dout = 1'b0;
    logic [7:0] accel, cds;
    logic       av, cv;
    logic       f_sck, f_ad, f_din;
    logic       f_dout = 1'b1;
    logic [7:0] f_accel, f_cds;
    logic       f_av, f_cv;

    int total = 0;
    int bad   = 0;

    adc_spi_master dut (
        .CLK(clk), .RST(rst), .SPI_SCK(sck), .SPI_AD(ad), .SPI_DIN(din), .SPI_DOUT(dout),
        .adc_accel(accel), .adc_cds(cds), .accel_valid(av), .cds_valid(cv)
    );

    adc_spi_master #(.CLK_DIV(2), .CONV_GAP(1)) dut_fast (
        .CLK(clk), .RST(rst), .SPI_SCK(f_sck), .SPI_AD(f_ad), .SPI_DIN(f_din), .SPI_DOUT(f_dout),
        .adc_accel(f_accel), .adc_cds(f_cds), .accel_valid(f_av), .cds_valid(f_cv)
    );

    always #10 clk = ~clk;

    // ADC model and frame monitor for the default-parameter instance
    int       cyc = 0;
    bit       prev_sck = 1'b0, prev_ad = 1'b1;
    int       pulses = 0, low_cnt = 0;
    bit [3:0] cmd;
    int       fr_low, fr_pulses, fr_sample, fr_ch;
    bit [3:0] fr_cmd;
    bit       sck_bad = 1'b0, both_bad = 1'b0;
    int       ch_val [2];
    int       hist_m [2][4];
    int       exp_out [2];

    always @(negedge clk) begin
        int v;
        cyc++;
        if (rst) begin
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < 4; i++) hist_m[c][i] = 0;
        end
        if (ad && sck) sck_bad = 1'b1;
        if ((av && cv) || (f_av && f_cv)) both_bad = 1'b1;
        if (!ad && prev_ad) begin
            pulses  = 0;
            low_cnt = 0;
        end
        if (!ad) low_cnt++;
        if (sck && !prev_sck) begin
            if (pulses < 4) cmd[pulses] = din;
            pulses++;
        end
        if (!sck && prev_sck) begin
            if (pulses >= 6 && pulses <= 17) begin
                if (pulses == 6) begin
                    fr_sample = ch_val[cmd[2]];
                    fr_ch     = int'(cmd[2]);
                end
                v    = fr_sample;
                dout = v[17 - pulses];
            end else begin
                dout = 1'b0;
            end
        end
        if (ad && !prev_ad) begin
            fr_low    = low_cnt;
            fr_pulses = pulses;
            fr_cmd    = cmd;
        end
        if (av || cv) begin
`ifdef ADC_AVG_EN
            for (int i = 3; i > 0; i--) hist_m[fr_ch][i] = hist_m[fr_ch][i-1];
            hist_m[fr_ch][0] = fr_sample;
            exp_out[fr_ch] = ((hist_m[fr_ch][0] + hist_m[fr_ch][1] + hist_m[fr_ch][2] + hist_m[fr_ch][3]) / 4) / 16;
`else
            exp_out[fr_ch] = fr_sample / 16;
`endif
        end
        prev_sck = sck;
        prev_ad  = ad;
    end

    task automatic wait_valid(input int budget, output bit got, output bit which, output int when);
        got = 1'b0; which = 1'b0; when = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk); #1;
            if (av || cv) begin
                got = 1'b1; which = cv; when = cyc;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        total++; if (sck !== 1'b0)  begin bad++; $display("FAIL reset_sck got %b want 0", sck); end
        total++; if (ad !== 1'b1)   begin bad++; $display("FAIL reset_ad got %b want 1", ad); end
        total++; if (din !== 1'b0)  begin bad++; $display("FAIL reset_din got %b want 0", din); end
        total++; if (accel !== 8'd0) begin bad++; $display("FAIL reset_accel got %0d want 0", accel); end
        total++; if (cds !== 8'd0)  begin bad++; $display("FAIL reset_cds got %0d want 0", cds); end
        total++; if (av !== 1'b0 || cv !== 1'b0) begin bad++; $display("FAIL reset_valid got %b%b want 00", av, cv); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit got, which; int t0, t1, t2;
        ch_val[0] = 1000; ch_val[1] = 2000;
        wait_valid(3000, got, which, t0);
        total++; if (!got || which !== 1'b0) begin bad++; $display("FAIL basic_first_accel got=%b which=%b want accel", got, which); end
        total++; if (accel !== 8'(exp_out[0])) begin bad++; $display("FAIL basic_accel got %0d want %0d", accel, exp_out[0]); end
`ifndef ADC_AVG_EN
        total++; if (accel !== 8'd62) begin bad++; $display("FAIL basic_accel_raw got %0d want 62", accel); end
`endif
        total++; if (fr_low != 925) begin bad++; $display("FAIL basic_cs_low got %0d want 925", fr_low); end
        total++; if (fr_pulses != 18) begin bad++; $display("FAIL basic_pulses got %0d want 18", fr_pulses); end
        total++; if (fr_cmd !== 4'b1011) begin bad++; $display("FAIL basic_cmd_ch0 got %b want 1011", fr_cmd); end
        wait_valid(3000, got, which, t1);
        total++; if (!got || which !== 1'b1) begin bad++; $display("FAIL basic_cds_next got=%b which=%b want cds", got, which); end
        total++; if (cds !== 8'(exp_out[1])) begin bad++; $display("FAIL basic_cds got %0d want %0d", cds, exp_out[1]); end
`ifndef ADC_AVG_EN
        total++; if (cds !== 8'd125) begin bad++; $display("FAIL basic_cds_raw got %0d want 125", cds); end
`endif
        total++; if (fr_cmd !== 4'b1111) begin bad++; $display("FAIL basic_cmd_ch1 got %b want 1111", fr_cmd); end
        total++; if (fr_pulses != 18) begin bad++; $display("FAIL basic_pulses_ch1 got %0d want 18", fr_pulses); end
        total++; if (t1 - t0 != 976) begin bad++; $display("FAIL basic_period got %0d want 976", t1 - t0); end
        wait_valid(3000, got, which, t2);
        total++; if (!got || which !== 1'b0 || t2 - t1 != 976) begin bad++; $display("FAIL basic_alternate got which=%b gap=%0d want accel gap 976", which, t2 - t1); end
    endtask

    task automatic test_steps();
        int steps [4] = '{1000, 4000, 4095, 0};
        int raw [4] = '{62, 250, 255, 0};
        bit got, which; int t;
        for (int s = 0; s < 4; s++) begin
            ch_val[0] = steps[s];
            which = 1'b1; got = 1'b1;
            for (int k = 0; k < 3 && got && which; k++) wait_valid(3000, got, which, t);
            total++; if (!got || which !== 1'b0) begin bad++; $display("FAIL step%0d_timeout got=%b", s, got); end
            total++; if (accel !== 8'(exp_out[0])) begin bad++; $display("FAIL step%0d_accel got %0d want %0d", s, accel, exp_out[0]); end
`ifndef ADC_AVG_EN
            total++; if (accel !== 8'(raw[s])) begin bad++; $display("FAIL step%0d_accel_raw got %0d want %0d", s, accel, raw[s]); end
`endif
            total++; if (cds !== 8'(exp_out[1])) begin bad++; $display("FAIL step%0d_cds_hold got %0d want %0d", s, cds, exp_out[1]); end
        end
    endtask

    task automatic test_random();
        bit got, which; int t;
        for (int n = 0; n < 6; n++) begin
            ch_val[0] = int'($urandom_range(0, 4095));
            ch_val[1] = int'($urandom_range(0, 4095));
            wait_valid(3000, got, which, t);
            total++; if (!got || which !== 1'b1 || cds !== 8'(exp_out[1])) begin bad++; $display("FAIL rand%0d_cds got %0d (valid=%b ch=%b) want %0d from %0d", n, cds, got, which, exp_out[1], ch_val[1]); end
            wait_valid(3000, got, which, t);
            total++; if (!got || which !== 1'b0 || accel !== 8'(exp_out[0])) begin bad++; $display("FAIL rand%0d_accel got %0d (valid=%b ch=%b) want %0d from %0d", n, accel, got, which, exp_out[0], ch_val[0]); end
        end
    endtask

    task automatic test_reset_mid();
        bit got, which, saw_valid; int t, hi, i;
        ch_val[0] = 3000; ch_val[1] = 1500;
        got = 1'b0;
        for (i = 0; i < 4000 && !got; i++) begin
            @(negedge clk); #1;
            if (!ad && cmd[2] && pulses == 11) got = 1'b1;
        end
        total++; if (!got) begin bad++; $display("FAIL midrst_find_r10 got timeout want ch1 r10"); end
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        total++; if (ad !== 1'b1 || sck !== 1'b0) begin bad++; $display("FAIL midrst_lines got ad=%b sck=%b want 1 0", ad, sck); end
        total++; if (accel !== 8'd0 || cds !== 8'd0) begin bad++; $display("FAIL midrst_outputs got %0d %0d want 0 0", accel, cds); end
        hi = 1; saw_valid = cv | av;
        for (i = 0; i < 200 && ad; i++) begin
            @(negedge clk); #1;
            if (ad) hi++;
            if (av || cv) saw_valid = 1'b1;
        end
        total++; if (saw_valid) begin bad++; $display("FAIL midrst_no_valid got valid want none"); end
        total++; if (hi != 50) begin bad++; $display("FAIL midrst_gap got %0d want 50", hi); end
        wait_valid(3000, got, which, t);
        total++; if (!got || which !== 1'b0 || fr_cmd !== 4'b1011) begin bad++; $display("FAIL midrst_next_ch0 got which=%b cmd=%b want accel 1011", which, fr_cmd); end
        total++; if (accel !== 8'(exp_out[0])) begin bad++; $display("FAIL midrst_accel got %0d want %0d", accel, exp_out[0]); end
    endtask

    task automatic test_fast();
        int low, rises, r0, r1, t0, t1, n;
        bit ps;
        n = 0;
        while (n < 100 && !f_ad) begin @(negedge clk); #1; n++; end
        while (n < 200 && f_ad) begin @(negedge clk); #1; n++; end
        low = 0; rises = 0; r0 = 0; r1 = 0; ps = f_sck;
        while (n < 400 && !f_ad) begin
            low++;
            @(negedge clk); #1; n++;
            if (f_sck && !ps) begin
                rises++;
                if (rises == 1) r0 = n;
                if (rises == 2) r1 = n;
            end
            ps = f_sck;
        end
        total++; if (low != 74) begin bad++; $display("FAIL fast_cs_low got %0d want 74", low); end
        total++; if (rises != 18) begin bad++; $display("FAIL fast_pulses got %0d want 18", rises); end
        total++; if (r1 - r0 != 4) begin bad++; $display("FAIL fast_sck_period got %0d want 4", r1 - r0); end
        t0 = -1; t1 = -1;
        for (int i = 0; i < 400 && t1 < 0; i++) begin
            @(negedge clk); #1;
            if (f_av || f_cv) begin
                if (t0 < 0) t0 = i; else t1 = i;
                if (f_av && f_accel !== 8'd255) begin bad++; total++; $display("FAIL fast_accel got %0d want 255", f_accel); end
                if (f_cv && f_cds !== 8'd255) begin bad++; total++; $display("FAIL fast_cds got %0d want 255", f_cds); end
            end
        end
        total++; if (t1 < 0 || t1 - t0 != 76) begin bad++; $display("FAIL fast_period got %0d want 76", t1 - t0); end
        total++; if (f_accel !== 8'd255 || f_cds !== 8'd255) begin bad++; $display("FAIL fast_values got %0d %0d want 255 255", f_accel, f_cds); end
    endtask

    initial begin
        ch_val[0] = 0; ch_val[1] = 0;
        exp_out[0] = 0; exp_out[1] = 0;
        test_reset();
        test_basic();
        test_steps();
        test_random();
        test_reset_mid();
        test_fast();
        total++; if (sck_bad) begin bad++; $display("FAIL sck_idle got SCK high with SPI_AD high want low"); end
        total++; if (both_bad) begin bad++; $display("FAIL valid_exclusive got both valids high want never"); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
